// File: rtl/popcnt_sched.sv
// popcnt_sched: round-robin scheduler sharing one bit-serial ones-counter
// between NREQ requesters. The winner's word is captured into a shift
// register and counted one bit per cycle; the result is returned with the
// requester ID.
// Optional build macro: POPCNT_ZERO_SKIP_EN -- end the count early once the
// remaining shifted word is all zeros (same count, shorter latency).
module popcnt_sched #(
  parameter int N    = 9,
  parameter int NREQ = 4,
  parameter int CW   = $clog2(N+1),
  parameter int IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     count,
  output logic [IW-1:0]     done_id
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N-1);

  state_t            state, state_next;
  logic [N-1:0]      shreg;
  logic [CW-1:0]     acc;
  logic [CW-1:0]     acc_sum;
  logic [CW-1:0]     bitcnt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     cur_id;
  logic [IW-1:0]     winner;
  logic [IW-1:0]     ptr_next;
  logic              found;
  logic              grant_fire;
  logic              skip;
  logic              finish;
  logic [NREQ-1:0]   onehot;
  logic [N-1:0]      words [NREQ];

  // Unpack the flat data bus into per-requester words and decode the winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign words[gi]  = data[gi*N +: N];
    assign onehot[gi] = (winner == IW'(gi));
  end

  // Round-robin pick: first asserted request scanning upward from ptr.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

  assign ptr_next = (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
  assign acc_sum  = acc + {{(CW-1){1'b0}}, shreg[0]};
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the grant / finish strobes used by the datapath.
  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    skip       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_fire = 1'b1;
          state_next = COUNT;
        end
      end
      COUNT: begin
`ifdef POPCNT_ZERO_SKIP_EN
        // Nothing left to count: finish without accumulating this cycle.
        skip = (shreg == '0);
`else
        skip = 1'b0;
`endif
        finish = skip || (bitcnt == LAST);
        if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on grant, shift/accumulate in COUNT, publish on finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      acc     <= '0;
      bitcnt  <= '0;
      ptr     <= '0;
      cur_id  <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      count   <= '0;
      done_id <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      if (grant_fire) begin
        shreg  <= words[winner];
        acc    <= '0;
        bitcnt <= '0;
        cur_id <= winner;
        gnt    <= onehot;
        ptr    <= ptr_next;
      end else if (state == COUNT) begin
        if (skip) begin
          count   <= acc;
          done_id <= cur_id;
          done    <= 1'b1;
        end else begin
          acc    <= acc_sum;
          shreg  <= shreg >> 1;
          bitcnt <= bitcnt + 1'b1;
          if (finish) begin
            count   <= acc_sum;
            done_id <= cur_id;
            done    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_popcnt_sched.sv
// Testbench for popcnt_sched: scoreboard of expected grants/results, pushed
// when a request is driven and popped when the DUT grants and finishes.
module tb_popcnt_sched;

  localparam int N    = 9;
  localparam int NREQ = 4;
  localparam int CW   = $clog2(N+1);
  localparam int IW   = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [CW-1:0]     count;
  logic [IW-1:0]     done_id;

  logic [N-1:0]      wd [NREQ];

  typedef struct {
    int id;
    int cnt;
    int lat;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   inflight  = 1'b0;
  bit   auto_drop = 1'b1;
  int   cyc       = 0;
  int   gnt_cyc   = 0;
  int   last_gnt  = 0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  popcnt_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    data = '0;
    for (int i = 0; i < NREQ; i++) data[i*N +: N] = wd[i];
  end

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Expected cycles from gnt to done for a word.
  function automatic int exp_lat(input logic [N-1:0] w);
`ifdef POPCNT_ZERO_SKIP_EN
    int h;
    h = -1;
    for (int i = 0; i < N; i++) if (w[i]) h = i;
    if (h < 0) return 1;
    return (h + 2 > N) ? N : h + 2;
`else
    return N;
`endif
  endfunction

  task automatic push(input int id, input int gap);
    exp_t e;
    e.id  = id;
    e.cnt = $countones(wd[id]);
    e.lat = exp_lat(wd[id]);
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // One clock: sample outputs 1 time unit after the edge and score them.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      inflight = 1'b0;
    end else begin
      if (inflight) check("busy_active", int'(busy), 1);
      if (gnt != '0) begin
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", int'(gnt), 0);
        end else begin
          e = exp_q.pop_front();
          check("gnt_onehot", int'(gnt), 1 << e.id);
          if (e.gap > 0) check("gnt_gap", cyc - last_gnt, e.gap);
          cur      = e;
          inflight = 1'b1;
          gnt_cyc  = cyc;
        end
        last_gnt = cyc;
      end
      if (done) begin
        if (!inflight) begin
          check("done_unexpected", 1, 0);
        end else begin
          check("done_id", int'(done_id), cur.id);
          check("count", int'(count), cur.cnt);
          check("latency", cyc - gnt_cyc, cur.lat);
          $display("txn id=%0d count=%0d latency=%0d", done_id, count, cyc - gnt_cyc);
          inflight = 1'b0;
        end
      end
      if (auto_drop) req = req & ~gnt;
    end
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || inflight) && n < budget) begin
      tick();
      n++;
    end
    check("drain", (exp_q.size() != 0 || inflight) ? 1 : 0, 0);
  endtask

  task automatic wait_gnt(input int budget);
    int n;
    n = 0;
    while (!inflight && n < budget) begin
      tick();
      n++;
    end
    check("gnt_wait", int'(inflight), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},     int'(gnt),     0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_done"},    int'(done),    0);
    check({tag, "_count"},   int'(count),   0);
    check({tag, "_done_id"}, int'(done_id), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < NREQ; i++) wd[i] = '0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single requester after reset.
    wd[0] = 9'h1BB;
    push(0, 0);
    req = 4'b0001;
    run_until_empty(40);
    tick();

    // Requester 3 with all-ones word; leaves ptr wrapped to 0.
    wd[3] = 9'h1FF;
    push(3, 0);
    req = 4'b1000;
    run_until_empty(40);
    tick();

    // All requesters held continuously: rotation 0,1,2,3.
    wd[0] = 9'h0BA;
    wd[1] = 9'h1B9;
    wd[2] = 9'h1FB;
    wd[3] = 9'h1F3;
    push(0, 0);
    push(1, exp_lat(wd[0]) + 2);
    push(2, exp_lat(wd[1]) + 2);
    push(3, exp_lat(wd[2]) + 2);
    auto_drop = 1'b0;
    req = 4'b1111;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("rotate_wait", exp_q.size(), 0);
    req = '0;
    auto_drop = 1'b1;
    run_until_empty(40);
    tick();

    // Pointer wrap: req 0 wins over req 3, then req 3 follows.
    wd[0] = 9'h003;
    wd[3] = 9'h100;
    push(0, 0);
    push(3, exp_lat(wd[0]) + 2);
    req = 4'b1001;
    run_until_empty(60);
    tick();

    // Boundary words.
    wd[2] = 9'h000;
    push(2, 0);
    req = 4'b0100;
    run_until_empty(40);
    tick();
    wd[1] = 9'h001;
    push(1, 0);
    req = 4'b0010;
    run_until_empty(40);
    tick();

    // Reset mid-COUNT: grant req 1, then reset 4 cycles after gnt.
    wd[1] = 9'h0FF;
    push(1, 0);
    req = 4'b0010;
    wait_gnt(10);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check_outputs_zero("midreset");
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    // ptr is back to 0, so req 0 beats req 1.
    wd[0] = 9'h155;
    wd[1] = 9'h0AA;
    push(0, 0);
    push(1, exp_lat(wd[0]) + 2);
    req = 4'b0011;
    run_until_empty(60);
    tick();

    // Data and req changes during COUNT are ignored.
    wd[2] = 9'h1C7;
    push(2, 0);
    req = 4'b0100;
    wait_gnt(10);
    wd[2] = 9'h001;
    run_until_empty(40);
    for (int i = 0; i < 20; i++) tick();
    check("idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/popcnt_sched.md
# popcnt_sched

Round-robin scheduler that shares one bit-serial ones-counter between `NREQ` requesters. Each requester presents an `N`-bit word and holds a request. The block grants one requester at a time, shifts the word through a single accumulator, and returns the number of set bits with the requester ID. It sits in front of the ones-counting datapath so that several consumers can use one counter instead of each instantiating its own.

## Interface
- `N`, 9: data word width.
- `NREQ`, 4: number of requesters, 2..8.
- `CW`, `$clog2(N+1)` (4 for N=9): count width.
- `IW`, `$clog2(NREQ)` (2): requester ID width.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req`  in  NREQ  per-requester request level.
- `data`  in  NREQ*N  word of requester i is on `data[i*N +: N]`.
- `gnt`  out  NREQ  one-hot, one-cycle pulse: the winner's word was captured.
- `busy`  out  1  high in COUNT and DONE.
- `done`  out  1  one-cycle pulse: `count` and `done_id` are valid.
- `count`  out  CW  number of ones in the granted word; holds until the next `done`.
- `done_id`  out  IW  index of the requester whose result is on `count`.

## Operation
- FSM states are IDLE, COUNT and DONE. Registers are `shreg[N-1:0]`, `acc[CW-1:0]`, `bitcnt`, `ptr[IW-1:0]` and `cur_id`.
- IDLE:
  - If `req` is nonzero, pick the first asserted requester scanning upward from `ptr` with wrap-around.
  - On the edge: `shreg` = winner's data, `acc` = 0, `bitcnt` = 0, `cur_id` = winner, `gnt[winner]` = 1, `ptr` = winner+1 (mod NREQ), state goes to COUNT.
- COUNT, each cycle:
  - `acc` += `shreg[0]`, `shreg` >>= 1, `bitcnt` += 1.
  - On the edge where `bitcnt` reaches N, load `count` = final `acc`, `done_id` = `cur_id`, `done` = 1, and go to DONE.
- DONE: one cycle, then IDLE. `done` drops on the edge into IDLE. `req` is not evaluated in DONE.
- Arbitration:
  - `gnt` is high only on the first COUNT cycle.
  - A requester must hold `req` and `data` stable until it sees its `gnt`.
  - A `req` still high after its grant is a new request and is arbitrated again.
- `req` and `data` changes during COUNT or DONE are ignored.
- Reset values: all outputs are 0, state is IDLE, `ptr` = 0 (requester 0 highest priority), and `shreg`, `acc`, `bitcnt` are 0.
- Reset mid-operation: the in-flight count is discarded and no `done` is produced. Requesters must re-request.
- Arithmetic: `acc` is never wider than CW and cannot overflow, because its maximum is N.

## Timing
- Request sampled in IDLE at edge k:
  - `gnt` high in cycle k+1.
  - COUNT occupies cycles k+1 .. k+N.
  - `done` high in cycle k+N+1.
  - IDLE again in cycle k+N+2.
- Latency from request sample to `done` is N+1 cycles; from request sample to next possible grant is N+2 cycles.
- Back-to-back: requester B waiting during A's operation is granted in the cycle after A's DONE.
- With all requesters asserted continuously, grants rotate 0,1,2,3,0,… with no starvation.
- If `rst_n` is low at an edge, reset wins over every other event on that edge.

## Configuration
- `POPCNT_ZERO_SKIP_EN`:
  - Defined: in COUNT, if `shreg == 0` at the start of a cycle, that cycle does not accumulate and the FSM goes to DONE on its edge. Latency becomes (index of highest set bit + 2) cycles, minimum 1 COUNT cycle: word 0 gives `done` in cycle k+2.
  - Undefined: always exactly N COUNT cycles. Latency is fixed at N+1 and independent of data.
  - `count` values are identical in both builds.

## Test plan
- Reset, then single requester: release `rst_n`, req[0]=1 with `9'h1BB` → `gnt`=0001 one cycle later; `done`=1, `count`=7, `done_id`=0 at k+10.
- All requesters, continuous: req=1111 with data[0..3] = `9'h0BA`, `9'h1B9`, `9'h1FB`, `9'h1F3` → grants 0,1,2,3 in order; counts 5,6,8,7 with matching `done_id`; 11 cycles between grants.
- Pointer wrap: after a grant to req 3, assert req=1001 → req 0 wins next, then req 3.
- Boundary data: `9'h000` gives count 0 and `9'h1FF` gives count 9; with `POPCNT_ZERO_SKIP_EN`, `9'h000` gives `done` at k+2 and `9'h001` at k+3.
- Reset mid-COUNT: pull `rst_n` low 4 cycles after `gnt` → no `done`, all outputs 0, `ptr`=0; next req=0010 is granted with full N+1 latency.
- Ignore changes: during COUNT, change the granted requester's `data` and drop `req` → `count` reflects the captured word, and the dropped requester is not re-granted.
